// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle MIPS-subset datapath.
// Sequences IF -> ID -> EX -> (MEM) -> (WB) and drives every datapath strobe.
//
// Ports (in order):
//   clk, rst_n        clock, asynchronous active-low reset
//   opcode, funct     instruction-register fields [31:26] and [5:0]
//   zero              ALU result-zero flag
//   mem_ready         memory finishes the current request this cycle
//   pc_we, ir_we      PC write, instruction-register write
//   pc_src            00 PC+4, 01 branch, 10 jump, 11 rs
//   mem_req, mem_we   memory request, store
//   iord              memory address select (0 = PC, 1 = data)
//   reg_we            register-file write enable
//   reg_dst           00 rd, 01 rt, 10 $31
//   wb_src            00 ALU, 01 memory data register, 10 PC
//   alu_srcb          00 rt, 01 extended immediate, 10 shamt
//   ext_op            00 zero, 01 signed, 10 high-half
//   alu_ctrl          ALU operation code
//   state             current FSM state
//   retire            instruction completes this cycle
//   illegal           sticky trap flag (only with ILLEGAL_TRAP_EN)
//
// Build option: define ILLEGAL_TRAP_EN to trap unsupported instructions in
// an absorbing TRAP state; otherwise they retire as NOPs from ID.

module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic [1:0] pc_src,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_src,
    output logic [1:0] alu_srcb,
    output logic [1:0] ext_op,
    output logic [4:0] alu_ctrl,
    output logic [2:0] state,
    output logic       retire,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4
`ifdef ILLEGAL_TRAP_EN
        ,
        S_TRAP = 3'd5
`endif
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_SLT  = 5'd4;
    localparam logic [4:0] ALU_SLL  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_ADDU = 5'd8;
    localparam logic [4:0] ALU_SUBU = 5'd9;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_SHAMT = 2'b10;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_HIGH = 2'b10;

    localparam logic [1:0] PCS_SEQ = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_J   = 2'b10;
    localparam logic [1:0] PCS_RS  = 2'b11;

    localparam logic [1:0] DST_RD  = 2'b00;
    localparam logic [1:0] DST_RT  = 2'b01;
    localparam logic [1:0] DST_RA  = 2'b10;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MDR  = 2'b01;
    localparam logic [1:0] WB_PC   = 2'b10;

    state_e state_q, state_d;

    // Instruction decode: one flag per supported instruction.
    logic is_r;
    logic i_addu, i_add, i_subu, i_sub, i_slt;
    logic i_sll, i_srl, i_sra, i_and, i_or, i_jr;
    logic i_ori, i_addi, i_slti, i_lui;
    logic i_lw, i_sw, i_beq, i_bne, i_j, i_jal;

    assign is_r   = (opcode == OP_RTYPE);
    assign i_addu = is_r && (funct == FN_ADDU);
    assign i_add  = is_r && (funct == FN_ADD);
    assign i_subu = is_r && (funct == FN_SUBU);
    assign i_sub  = is_r && (funct == FN_SUB);
    assign i_slt  = is_r && (funct == FN_SLT);
    assign i_sll  = is_r && (funct == FN_SLL);
    assign i_srl  = is_r && (funct == FN_SRL);
    assign i_sra  = is_r && (funct == FN_SRA);
    assign i_and  = is_r && (funct == FN_AND);
    assign i_or   = is_r && (funct == FN_OR);
    assign i_jr   = is_r && (funct == FN_JR);
    assign i_ori  = (opcode == OP_ORI);
    assign i_addi = (opcode == OP_ADDI);
    assign i_slti = (opcode == OP_SLTI);
    assign i_lui  = (opcode == OP_LUI);
    assign i_lw   = (opcode == OP_LW);
    assign i_sw   = (opcode == OP_SW);
    assign i_beq  = (opcode == OP_BEQ);
    assign i_bne  = (opcode == OP_BNE);
    assign i_j    = (opcode == OP_J);
    assign i_jal  = (opcode == OP_JAL);

    logic       dec_legal;
    logic       dec_wb;
    logic       dec_mem;
    logic [4:0] dec_alu;
    logic [1:0] dec_srcb;
    logic [1:0] dec_ext;

    always_comb begin
        dec_legal = 1'b1;
        dec_wb    = 1'b0;
        dec_mem   = 1'b0;
        dec_alu   = ALU_ADD;
        dec_srcb  = SRCB_RT;
        dec_ext   = EXT_ZERO;
        unique case (1'b1)
            i_addu: begin dec_alu = ALU_ADDU; dec_wb = 1'b1; end
            i_add:  begin dec_alu = ALU_ADD;  dec_wb = 1'b1; end
            i_subu: begin dec_alu = ALU_SUBU; dec_wb = 1'b1; end
            i_sub:  begin dec_alu = ALU_SUB;  dec_wb = 1'b1; end
            i_slt:  begin dec_alu = ALU_SLT;  dec_wb = 1'b1; end
            i_and:  begin dec_alu = ALU_AND;  dec_wb = 1'b1; end
            i_or:   begin dec_alu = ALU_OR;   dec_wb = 1'b1; end
            i_sll: begin
                dec_alu  = ALU_SLL;
                dec_srcb = SRCB_SHAMT;
                dec_wb   = 1'b1;
            end
            i_srl: begin
                dec_alu  = ALU_SRL;
                dec_srcb = SRCB_SHAMT;
                dec_wb   = 1'b1;
            end
            i_sra: begin
                dec_alu  = ALU_SRA;
                dec_srcb = SRCB_SHAMT;
                dec_wb   = 1'b1;
            end
            i_ori: begin
                dec_alu  = ALU_OR;
                dec_srcb = SRCB_IMM;
                dec_ext  = EXT_ZERO;
                dec_wb   = 1'b1;
            end
            i_addi: begin
                dec_alu  = ALU_ADD;
                dec_srcb = SRCB_IMM;
                dec_ext  = EXT_SIGN;
                dec_wb   = 1'b1;
            end
            i_slti: begin
                dec_alu  = ALU_SLT;
                dec_srcb = SRCB_IMM;
                dec_ext  = EXT_SIGN;
                dec_wb   = 1'b1;
            end
            i_lui: begin
                dec_alu  = ALU_OR;
                dec_srcb = SRCB_IMM;
                dec_ext  = EXT_HIGH;
                dec_wb   = 1'b1;
            end
            i_lw, i_sw: begin
                dec_alu  = ALU_ADD;
                dec_srcb = SRCB_IMM;
                dec_ext  = EXT_SIGN;
                dec_mem  = 1'b1;
            end
            // Branch compare: rs - rt, taken decision uses zero.
            i_beq, i_bne: begin
                dec_alu  = ALU_SUB;
                dec_srcb = SRCB_RT;
                dec_ext  = EXT_SIGN;
            end
            i_jr, i_j, i_jal: ;
            default: dec_legal = 1'b0;
        endcase
    end

    // Unqualified strobes; gated with rst_n below.
    logic       pc_we_c, ir_we_c, mem_req_c, mem_we_c, iord_c;
    logic       reg_we_c, retire_c;
    logic [1:0] pc_src_c, reg_dst_c, wb_src_c, alu_srcb_c, ext_op_c;
    logic [4:0] alu_ctrl_c;

    always_comb begin
        state_d    = state_q;
        pc_we_c    = 1'b0;
        ir_we_c    = 1'b0;
        pc_src_c   = PCS_SEQ;
        mem_req_c  = 1'b0;
        mem_we_c   = 1'b0;
        iord_c     = 1'b0;
        reg_we_c   = 1'b0;
        reg_dst_c  = DST_RD;
        wb_src_c   = WB_ALU;
        alu_srcb_c = SRCB_RT;
        ext_op_c   = EXT_ZERO;
        alu_ctrl_c = ALU_ADD;
        retire_c   = 1'b0;
        unique case (state_q)
            S_IF: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_we_c = 1'b1;
                    pc_we_c = 1'b1;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                if (dec_legal) begin
                    state_d = S_EX;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    retire_c = 1'b1;
                    state_d  = S_IF;
`endif
                end
            end
            S_EX: begin
                alu_ctrl_c = dec_alu;
                alu_srcb_c = dec_srcb;
                ext_op_c   = dec_ext;
                if (i_beq || i_bne) begin
                    pc_src_c = PCS_BR;
                    pc_we_c  = (i_beq && zero) || (i_bne && !zero);
                end
                if (i_j || i_jal) begin
                    pc_src_c = PCS_J;
                    pc_we_c  = 1'b1;
                end
                if (i_jr) begin
                    pc_src_c = PCS_RS;
                    pc_we_c  = 1'b1;
                end
                // jal links in EX so it can finish without a WB state.
                if (i_jal) begin
                    reg_we_c  = 1'b1;
                    reg_dst_c = DST_RA;
                    wb_src_c  = WB_PC;
                end
                if (dec_mem) begin
                    state_d = S_MEM;
                end else if (dec_wb) begin
                    state_d = S_WB;
                end else begin
                    retire_c = 1'b1;
                    state_d  = S_IF;
                end
            end
            S_MEM: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
                mem_we_c  = i_sw;
                if (mem_ready) begin
                    if (i_sw) begin
                        retire_c = 1'b1;
                        state_d  = S_IF;
                    end else begin
                        state_d  = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we_c  = 1'b1;
                reg_dst_c = is_r ? DST_RD : DST_RT;
                wb_src_c  = i_lw ? WB_MDR : WB_ALU;
                retire_c  = 1'b1;
                state_d   = S_IF;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: state_d = S_TRAP;
`endif
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset forces every output low, even though state_q sits in IF.
    assign pc_we    = rst_n & pc_we_c;
    assign ir_we    = rst_n & ir_we_c;
    assign pc_src   = {2{rst_n}} & pc_src_c;
    assign mem_req  = rst_n & mem_req_c;
    assign mem_we   = rst_n & mem_we_c;
    assign iord     = rst_n & iord_c;
    assign reg_we   = rst_n & reg_we_c;
    assign reg_dst  = {2{rst_n}} & reg_dst_c;
    assign wb_src   = {2{rst_n}} & wb_src_c;
    assign alu_srcb = {2{rst_n}} & alu_srcb_c;
    assign ext_op   = {2{rst_n}} & ext_op_c;
    assign alu_ctrl = {5{rst_n}} & alu_ctrl_c;
    assign retire   = rst_n & retire_c;
    assign state    = state_q;

`ifdef ILLEGAL_TRAP_EN
    assign illegal  = rst_n & (state_q == S_TRAP);
`else
    assign illegal  = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed scoreboard bench for multicycle_ctrl.
// Stimulus pushes per-cycle expected outputs; a monitor pops and compares.

module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_we, ir_we, mem_req, mem_we, iord, reg_we;
    logic       retire, illegal;
    logic [1:0] pc_src, reg_dst, wb_src, alu_srcb, ext_op;
    logic [4:0] alu_ctrl;
    logic [2:0] state;

    typedef struct packed {
        logic [2:0] st;
        logic       pc_we;
        logic       ir_we;
        logic [1:0] pc_src;
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wb_src;
        logic [1:0] srcb;
        logic [1:0] ext;
        logic [4:0] alu;
        logic       retire;
        logic       illegal;
    } exp_t;

    exp_t  act;
    exp_t  q[$];
    string nq[$];
    int    vecs = 0;
    int    miss = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready),
        .pc_we(pc_we), .ir_we(ir_we), .pc_src(pc_src),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .reg_we(reg_we), .reg_dst(reg_dst), .wb_src(wb_src),
        .alu_srcb(alu_srcb), .ext_op(ext_op), .alu_ctrl(alu_ctrl),
        .state(state), .retire(retire), .illegal(illegal)
    );

    assign act = {state, pc_we, ir_we, pc_src, mem_req, mem_we, iord,
                  reg_we, reg_dst, wb_src, alu_srcb, ext_op, alu_ctrl,
                  retire, illegal};

    // ALU codes used by the design
    localparam logic [4:0] A_ADD = 5'd0, A_SUB = 5'd1, A_OR = 5'd3;
    localparam logic [4:0] A_SLT = 5'd4, A_SLL = 5'd5, A_ADDU = 5'd8;

    function automatic exp_t mk(
        logic [2:0] st, logic pw, logic iw, logic [1:0] ps,
        logic mr, logic mw, logic io, logic rw, logic [1:0] rd,
        logic [1:0] wb, logic [1:0] sb, logic [1:0] ex,
        logic [4:0] al, logic rt, logic il);
        return {st, pw, iw, ps, mr, mw, io, rw, rd, wb, sb, ex, al, rt, il};
    endfunction

    function automatic exp_t e_zero();
        return mk(3'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                  2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 1'b0, 1'b0);
    endfunction

    function automatic exp_t e_if(logic rdy);
        return mk(3'd0, rdy, rdy, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0,
                  2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 1'b0, 1'b0);
    endfunction

    function automatic exp_t e_id(logic rt);
        return mk(3'd1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                  2'b00, 2'b00, 2'b00, 2'b00, 5'd0, rt, 1'b0);
    endfunction

    function automatic exp_t e_ex(
        logic [4:0] al, logic [1:0] sb, logic [1:0] ex, logic pw,
        logic [1:0] ps, logic rw, logic [1:0] rd, logic [1:0] wb,
        logic rt);
        return mk(3'd2, pw, 1'b0, ps, 1'b0, 1'b0, 1'b0, rw,
                  rd, wb, sb, ex, al, rt, 1'b0);
    endfunction

    function automatic exp_t e_mem(logic mw, logic rt);
        return mk(3'd3, 1'b0, 1'b0, 2'b00, 1'b1, mw, 1'b1, 1'b0,
                  2'b00, 2'b00, 2'b00, 2'b00, 5'd0, rt, 1'b0);
    endfunction

    function automatic exp_t e_wb(logic [1:0] rd, logic [1:0] wb);
        return mk(3'd4, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1,
                  rd, wb, 2'b00, 2'b00, 5'd0, 1'b1, 1'b0);
    endfunction

    function automatic exp_t e_trap();
        return mk(3'd5, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                  2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 1'b0, 1'b1);
    endfunction

    task automatic push(input exp_t e, input string nm);
        q.push_back(e);
        nq.push_back(nm);
    endtask

    task automatic step(input logic rdy, input logic z,
                        input exp_t e, input string nm);
        @(posedge clk);
        #1;
        mem_ready = rdy;
        zero      = z;
        push(e, nm);
    endtask

    task automatic fetch(input logic [5:0] op, input logic [5:0] fn,
                         input logic rdy, input string nm);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        opcode    = op;
        funct     = fn;
        mem_ready = rdy;
        zero      = 1'b0;
        push(e_if(rdy), nm);
    endtask

    task automatic rst_step(input string nm);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        push(e_zero(), nm);
    endtask

    // Monitor: compares DUT outputs each cycle an expectation is pending.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e  = q.pop_front();
                nm = nq.pop_front();
                vecs++;
                if (act !== e) begin
                    miss++;
                    $display("FAIL %s: got %h want %h (state %0d want %0d)",
                             nm, act, e, act.st, e.st);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset; mem_ready high must not leak through
        rst_step("reset0");
        rst_step("reset1");

        // addu: IF wait, then IF ID EX WB; mem_ready ignored in ID/EX
        fetch(6'h00, 6'h21, 1'b0, "addu_if_wait");
        step(1'b1, 1'b0, e_if(1'b1), "addu_if");
        step(1'b1, 1'b0, e_id(1'b0), "addu_id");
        step(1'b1, 1'b0, e_ex(A_ADDU, 2'b00, 2'b00, 1'b0, 2'b00,
                               1'b0, 2'b00, 2'b00, 1'b0), "addu_ex");
        step(1'b0, 1'b0, e_wb(2'b00, 2'b00), "addu_wb");

        // lw: MEM held 3 cycles, then WB from MDR
        fetch(6'h23, 6'h00, 1'b1, "lw_if");
        step(1'b0, 1'b0, e_id(1'b0), "lw_id");
        step(1'b0, 1'b0, e_ex(A_ADD, 2'b01, 2'b01, 1'b0, 2'b00,
                               1'b0, 2'b00, 2'b00, 1'b0), "lw_ex");
        step(1'b0, 1'b0, e_mem(1'b0, 1'b0), "lw_mem_w1");
        step(1'b0, 1'b0, e_mem(1'b0, 1'b0), "lw_mem_w2");
        step(1'b0, 1'b0, e_mem(1'b0, 1'b0), "lw_mem_w3");
        step(1'b1, 1'b0, e_mem(1'b0, 1'b0), "lw_mem_done");
        step(1'b0, 1'b0, e_wb(2'b01, 2'b01), "lw_wb");

        // beq taken / not taken, bne taken
        fetch(6'h04, 6'h00, 1'b1, "beq1_if");
        step(1'b0, 1'b1, e_id(1'b0), "beq1_id");
        step(1'b0, 1'b1, e_ex(A_SUB, 2'b00, 2'b01, 1'b1, 2'b01,
                               1'b0, 2'b00, 2'b00, 1'b1), "beq_taken");
        fetch(6'h04, 6'h00, 1'b1, "beq0_if");
        step(1'b0, 1'b0, e_id(1'b0), "beq0_id");
        step(1'b0, 1'b0, e_ex(A_SUB, 2'b00, 2'b01, 1'b0, 2'b01,
                               1'b0, 2'b00, 2'b00, 1'b1), "beq_not_taken");
        fetch(6'h05, 6'h00, 1'b1, "bne_if");
        step(1'b0, 1'b0, e_id(1'b0), "bne_id");
        step(1'b0, 1'b0, e_ex(A_SUB, 2'b00, 2'b01, 1'b1, 2'b01,
                               1'b0, 2'b00, 2'b00, 1'b1), "bne_taken");

        // jal links in EX; jr uses rs; j jumps
        fetch(6'h03, 6'h00, 1'b1, "jal_if");
        step(1'b0, 1'b0, e_id(1'b0), "jal_id");
        step(1'b0, 1'b0, e_ex(A_ADD, 2'b00, 2'b00, 1'b1, 2'b10,
                               1'b1, 2'b10, 2'b10, 1'b1), "jal_ex");
        fetch(6'h00, 6'h08, 1'b1, "jr_if");
        step(1'b0, 1'b0, e_id(1'b0), "jr_id");
        step(1'b0, 1'b0, e_ex(A_ADD, 2'b00, 2'b00, 1'b1, 2'b11,
                               1'b0, 2'b00, 2'b00, 1'b1), "jr_ex");
        fetch(6'h02, 6'h00, 1'b1, "j_if");
        step(1'b0, 1'b0, e_id(1'b0), "j_id");
        step(1'b0, 1'b0, e_ex(A_ADD, 2'b00, 2'b00, 1'b1, 2'b10,
                               1'b0, 2'b00, 2'b00, 1'b1), "j_ex");

        // sll shamt source; ori / lui / slti immediate forms
        fetch(6'h00, 6'h00, 1'b1, "sll_if");
        step(1'b0, 1'b0, e_id(1'b0), "sll_id");
        step(1'b0, 1'b0, e_ex(A_SLL, 2'b10, 2'b00, 1'b0, 2'b00,
                               1'b0, 2'b00, 2'b00, 1'b0), "sll_ex");
        step(1'b0, 1'b0, e_wb(2'b00, 2'b00), "sll_wb");
        fetch(6'h0D, 6'h25, 1'b1, "ori_if");
        step(1'b0, 1'b0, e_id(1'b0), "ori_id");
        step(1'b0, 1'b0, e_ex(A_OR, 2'b01, 2'b00, 1'b0, 2'b00,
                               1'b0, 2'b00, 2'b00, 1'b0), "ori_ex");
        step(1'b0, 1'b0, e_wb(2'b01, 2'b00), "ori_wb");
        fetch(6'h0F, 6'h00, 1'b1, "lui_if");
        step(1'b0, 1'b0, e_id(1'b0), "lui_id");
        step(1'b0, 1'b0, e_ex(A_OR, 2'b01, 2'b10, 1'b0, 2'b00,
                               1'b0, 2'b00, 2'b00, 1'b0), "lui_ex");
        step(1'b0, 1'b0, e_wb(2'b01, 2'b00), "lui_wb");
        fetch(6'h0A, 6'h00, 1'b1, "slti_if");
        step(1'b0, 1'b0, e_id(1'b0), "slti_id");
        step(1'b0, 1'b0, e_ex(A_SLT, 2'b01, 2'b01, 1'b0, 2'b00,
                               1'b0, 2'b00, 2'b00, 1'b0), "slti_ex");
        step(1'b0, 1'b0, e_wb(2'b01, 2'b00), "slti_wb");

        // sw completing normally
        fetch(6'h2B, 6'h00, 1'b1, "sw_if");
        step(1'b0, 1'b0, e_id(1'b0), "sw_id");
        step(1'b0, 1'b0, e_ex(A_ADD, 2'b01, 2'b01, 1'b0, 2'b00,
                               1'b0, 2'b00, 2'b00, 1'b0), "sw_ex");
        step(1'b1, 1'b0, e_mem(1'b1, 1'b1), "sw_mem_done");

        // sw aborted by reset mid MEM wait
        fetch(6'h2B, 6'h00, 1'b1, "swr_if");
        step(1'b0, 1'b0, e_id(1'b0), "swr_id");
        step(1'b0, 1'b0, e_ex(A_ADD, 2'b01, 2'b01, 1'b0, 2'b00,
                               1'b0, 2'b00, 2'b00, 1'b0), "swr_ex");
        step(1'b0, 1'b0, e_mem(1'b1, 1'b0), "swr_mem_wait");
        rst_step("swr_abort");
        rst_step("swr_reset_hold");
        fetch(6'h3F, 6'h00, 1'b1, "restart_if");

        // unsupported opcode 0x3F
`ifdef ILLEGAL_TRAP_EN
        step(1'b1, 1'b0, e_id(1'b0), "ill_id");
        step(1'b1, 1'b0, e_trap(), "ill_trap1");
        step(1'b1, 1'b0, e_trap(), "ill_trap2");
        step(1'b1, 1'b1, e_trap(), "ill_trap3");
        rst_step("ill_reset");
`else
        step(1'b1, 1'b0, e_id(1'b1), "ill_id_nop");
`endif
        fetch(6'h00, 6'h21, 1'b0, "final_if");

        @(posedge clk);
        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            miss++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low; ports are ordered as listed below.
REQ-002 Port clk, input, 1 bit: rising-edge clock.
REQ-003 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 Port opcode, input, 6 bits: instruction-register bits 31:26.
REQ-005 Port funct, input, 6 bits: instruction-register bits 5:0.
REQ-006 Port zero, input, 1 bit: ALU result-zero flag.
REQ-007 Port mem_ready, input, 1 bit: memory completes the current request this cycle.
REQ-008 Port pc_we / ir_we, output, 1 bit each: PC write / instruction-register write.
REQ-009 Port pc_src, output, 2 bits: 00 = PC+4, 01 = branch target, 10 = jump target, 11 = rs.
REQ-010 Port mem_req / mem_we / iord, output, 1 bit each: memory request / store / data-address select (0 = PC).
REQ-011 Port reg_we, output, 1 bit: register-file write enable.
REQ-012 Port reg_dst, output, 2 bits: 00 = rd, 01 = rt, 10 = $31.
REQ-013 Port wb_src, output, 2 bits: 00 = ALU, 01 = memory data register, 10 = PC.
REQ-014 Port alu_srcb, output, 2 bits: 00 = rt, 01 = extended immediate, 10 = shamt.
REQ-015 Ports ext_op (2 bits: 00 zero, 01 signed, 10 high-half) and alu_ctrl (5 bits, shared ALUOp codes), outputs.
REQ-016 Ports state (3 bits), retire (1 bit) and illegal (1 bit), outputs.

Function
REQ-017 State encoding SHALL be IF = 0, ID = 1, EX = 2, MEM = 3, WB = 4, TRAP = 5; all outputs are combinational from state, opcode, funct, zero and mem_ready.
REQ-018 IF: mem_req = 1, iord = 0; while mem_ready = 0, the block stays in IF; on mem_ready = 1, ir_we = 1, pc_we = 1 with pc_src = 00, and the next state is ID.
REQ-019 ID: no writes; the next state is EX for a supported instruction, else per REQ-027.
REQ-020 Supported instructions: R-type addu, add, subu, sub, slt, sll, srl, sra, and, or, jr; I-type ori, addi, slti, lui, lw, sw, beq, bne; J-type j, jal.
REQ-021 EX: alu_ctrl, ext_op and alu_srcb SHALL be driven per instruction: ori = zero-extend/OR; addi, lw, sw = signed/ADD; slti = signed/SLT; lui = high-half/OR; beq, bne = signed/SUB on rt; shifts use alu_srcb = 10.
REQ-022 EX next state: ALU ops go to WB; lw and sw go to MEM; all others go to IF with retire = 1.
REQ-023 EX branch: pc_we = (beq & zero) | (bne & ~zero), with pc_src = 01.
REQ-024 EX jump: j sets pc_we = 1, pc_src = 10; jr sets pc_we = 1, pc_src = 11; jal additionally sets reg_we = 1, reg_dst = 10, wb_src = 10 in the same cycle.
REQ-025 MEM: mem_req = 1, iord = 1, mem_we = sw; the block holds until mem_ready; then sw goes to IF with retire = 1, and lw goes to WB.
REQ-026 WB: reg_we = 1; reg_dst = 00 for R-type, else 01; wb_src = 01 for lw, else 00; retire = 1; next state is IF.
REQ-027 Unsupported opcode/funct (ILLEGAL_TRAP_EN, REQ-032): without the macro the block SHALL go ID -> IF with retire = 1 (NOP); with it, the block goes to TRAP.
REQ-028 Outputs not named for a state SHALL be 0; mem_ready outside IF/MEM SHALL be ignored.

Reset
REQ-029 While rst_n = 0, state SHALL be IF and every output SHALL be 0, including qualified pc_we, ir_we and mem_req; illegal SHALL be 0.
REQ-030 Reset asserted in any state, including mid-MEM wait, SHALL abort immediately with no write strobes; after release, fetch restarts in IF.
REQ-031 The first mem_req SHALL appear in the first cycle after rst_n rises.

Configuration
REQ-032 With macro ILLEGAL_TRAP_EN defined, TRAP SHALL be absorbing until reset, with illegal = 1 (sticky) and all strobes 0; without the macro, TRAP and illegal are absent and illegal is tied to 0.

Verification
REQ-033 addu (opcode 0x00, funct 0x21) with mem_ready high in IF -> states IF, ID, EX, WB; reg_we = 1, reg_dst = 00 in WB; retire after 4 cycles.
REQ-034 lw (0x23) with mem_ready delayed 3 cycles in MEM -> MEM held 3 cycles, mem_we = 0, iord = 1; WB with wb_src = 01.
REQ-035 beq (0x04) with zero = 1 -> pc_we = 1, pc_src = 01 in EX; with zero = 0 -> pc_we = 0; both return to IF.
REQ-036 jal (0x03) -> in EX: reg_we = 1, reg_dst = 10, wb_src = 10, pc_we = 1, pc_src = 10; next state IF.
REQ-037 rst_n pulsed low during the MEM wait of sw (0x2B) -> all outputs 0 at once, no mem_we; state = IF after release.
REQ-038 Opcode 0x3F -> with ILLEGAL_TRAP_EN: TRAP, illegal = 1 held; without it: back to IF, retire = 1.
